// File: rtl/if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_queue
// Brief    : Sequential instruction prefetch queue feeding the IF/ID register.
//            Optional IFQ_PERF_EN adds an empty-cycle counter port.
// Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         redirect_i,
    input  logic [31:0]                  redirect_pc_i,
    output logic                         imem_req_o,
    output logic [31:0]                  imem_addr_o,
    input  logic                         imem_ack_i,
    input  logic [31:0]                  imem_data_i,
    input  logic                         deq_i,
    output logic                         valid_o,
    output logic [31:0]                  pc_o,
    output logic [31:0]                  inst_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0]                  empty_cycles_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        addr_q, addr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        pc_mem_q [DEPTH];
    logic [31:0]        pc_mem_d [DEPTH];
    logic [31:0]        inst_mem_q [DEPTH];
    logic [31:0]        inst_mem_d [DEPTH];
    logic               push;
    logic               pop;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        push       = 1'b0;

        // Issuing only while count < DEPTH reserves the slot the data will land in.
        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !redirect_i && (count_q < CNT_W'(DEPTH))) begin
                    state_d = ST_REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            ST_REQ: begin
                if (redirect_i) begin
                    state_d = imem_ack_i ? ST_IDLE : ST_DROP;
                end else if (imem_ack_i) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (imem_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pop = deq_i && (count_q != '0) && !redirect_i;

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]   = addr_q;
                inst_mem_d[wr_ptr_q] = imem_data_i;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
                fetch_pc_d           = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pc_mem_q   <= pc_mem_d;
            inst_mem_q <= inst_mem_d;
        end
    end

    assign imem_req_o  = (state_q != ST_IDLE);
    assign imem_addr_o = addr_q;
    assign valid_o     = (count_q != '0);
    assign pc_o        = valid_o ? pc_mem_q[rd_ptr_q]   : 32'h0;
    assign inst_o      = valid_o ? inst_mem_q[rd_ptr_q] : 32'h0;
    assign count_o     = count_q;

`ifdef IFQ_PERF_EN
    logic [31:0] empty_cycles_q, empty_cycles_d;

    always_comb begin
        empty_cycles_d = empty_cycles_q;
        if (!valid_o && start_i && (empty_cycles_q != 32'hFFFF_FFFF)) begin
            empty_cycles_d = empty_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            empty_cycles_q <= '0;
        end else begin
            empty_cycles_q <= empty_cycles_d;
        end
    end

    assign empty_cycles_o = empty_cycles_q;
`endif

endmodule
`default_nettype wire
